// File: rtl/timer_pkg.sv
// Shared types and defaults for the interval timer controller.
// Optional prescaler is built when TIMER_CTRL_PRESCALE_EN is defined.
package timer_pkg;

  localparam int TIMER_WIDTH        = 4;
  localparam int TIMER_RESET_PERIOD = 10;

  typedef logic [TIMER_WIDTH-1:0] count_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/timer_prescale.sv
// Prescale counter producing one step strobe every PRESCALE run clocks.
// Only instantiated when TIMER_CTRL_PRESCALE_EN is defined.
module timer_prescale
  import timer_pkg::*;
#(
  parameter int unsigned PRESCALE = 4
) (
  input  logic clock,
  input  logic reset_n,
  input  logic run,
  input  logic hold,
  input  logic clr,
  output logic step
);

  localparam int PW =
    (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PMAX =
    PW'(PRESCALE - 1);

  logic [PW-1:0] pcnt;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pcnt <= '0;
    end else if (clr) begin
      pcnt <= '0;
    end else if (run && !hold) begin
      pcnt <= (pcnt == PMAX) ? '0 : pcnt + PW'(1);
    end
  end

  assign step = run && (pcnt == PMAX);

endmodule

// File: rtl/timer_ctrl.sv
// Programmable interval timer: one-shot/periodic, start/stop, tick.
// Define TIMER_CTRL_PRESCALE_EN to divide the count rate by PRESCALE.
module timer_ctrl
  import timer_pkg::*;
#(
  parameter int WIDTH        = TIMER_WIDTH,
  parameter int RESET_PERIOD = TIMER_RESET_PERIOD,
  parameter int PRESCALE     = 4
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [WIDTH-1:0] cfg_period,
  input  logic             cfg_periodic,
  input  logic             start,
  input  logic             stop,
  output logic [WIDTH-1:0] count,
  output logic             running,
  output logic             tick,
  output logic             done
);

  localparam int unsigned PRE =
    (PRESCALE < 1) ? 1 : PRESCALE;

  state_t           state;
  logic [WIDTH-1:0] period;
  logic             periodic;
  logic [WIDTH-1:0] last;
  logic             accept;
  logic             step;

  assign last   = period - WIDTH'(1);
  assign accept = cfg_valid && cfg_ready;

`ifdef TIMER_CTRL_PRESCALE_EN
  timer_prescale #(
    .PRESCALE (PRE)
  ) u_prescale (
    .clock   (clock),
    .reset_n (reset_n),
    .run     (state == ST_RUN),
    .hold    (stop),
    .clr     ((state == ST_IDLE) || (state == ST_DONE)),
    .step    (step)
  );
`else
  assign step = (PRE >= 1);
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      count    <= '0;
      period   <= WIDTH'(RESET_PERIOD);
      periodic <= 1'b1;
    end else begin
      if (accept) begin
        period   <= cfg_period;
        periodic <= cfg_periodic;
      end
      unique case (state)
        ST_IDLE: begin
          if (start && !stop) begin
            state <= ST_RUN;
            count <= '0;
          end
        end
        ST_RUN: begin
          if (stop) begin
            state <= ST_PAUSE;
          end else if (step) begin
            if (count != last) begin
              count <= count + WIDTH'(1);
            end else begin
              count <= '0;
              if (!periodic) state <= ST_DONE;
            end
          end
        end
        ST_PAUSE: begin
          if (stop) begin
            state <= ST_IDLE;
            count <= '0;
          end else if (start) begin
            state <= ST_RUN;
          end
        end
        ST_DONE: begin
          if (start && !stop) begin
            state <= ST_RUN;
            count <= '0;
          end else if (accept) begin
            state <= ST_IDLE;
            count <= '0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // All outputs decode registered state only
  assign cfg_ready = (state == ST_IDLE) ||
                     (state == ST_DONE);
  assign running   = (state == ST_RUN);
  assign done      = (state == ST_DONE);
  assign tick      = (state == ST_RUN) &&
                     (count == last) && step;

endmodule

// File: tb/tb_timer_ctrl.sv
// Directed self-checking bench for timer_ctrl (WIDTH=4).
// Prescale section runs when TIMER_CTRL_PRESCALE_EN is defined.
module tb_timer_ctrl;

  logic       clock;
  logic       reset_n;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [3:0] cfg_period;
  logic       cfg_periodic;
  logic       start;
  logic       stop;
  logic [3:0] count;
  logic       running;
  logic       tick;
  logic       done;

  int checks = 0;
  int errors = 0;
  int ticks;

  timer_ctrl #(
    .WIDTH        (4),
    .RESET_PERIOD (10),
    .PRESCALE     (4)
  ) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .cfg_valid    (cfg_valid),
    .cfg_ready    (cfg_ready),
    .cfg_period   (cfg_period),
    .cfg_periodic (cfg_periodic),
    .start        (start),
    .stop         (stop),
    .count        (count),
    .running      (running),
    .tick         (tick),
    .done         (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  initial begin
    reset_n      = 1'b0;
    cfg_valid    = 1'b0;
    cfg_period   = 4'd0;
    cfg_periodic = 1'b0;
    start        = 1'b0;
    stop         = 1'b0;
    cyc();
    cyc();
    chk("rst_count", count, 0);
    chk("rst_running", running, 0);
    chk("rst_tick", tick, 0);
    chk("rst_done", done, 0);
    chk("rst_ready", cfg_ready, 1);
    reset_n = 1'b1;
    cyc();

`ifndef TIMER_CTRL_PRESCALE_EN
    // default period 10, periodic
    start = 1'b1;
    cyc();
    start = 1'b0;
    chk("t1_run", running, 1);
    chk("t1_cnt0", count, 0);
    for (int k = 1; k < 20; k++) begin
      cyc();
      chk("t1_cnt", count, k % 10);
      chk("t1_tick", tick, (k % 10) == 9);
      chk("t1_done", done, 0);
    end
    stop = 1'b1;
    cyc();
    chk("t1_pause_cnt", count, 9);
    chk("t1_pause_run", running, 0);
    cyc();
    stop = 1'b0;
    chk("t1_idle_cnt", count, 0);

    // one-shot period 3
    cfg_valid    = 1'b1;
    cfg_period   = 4'd3;
    cfg_periodic = 1'b0;
    cyc();
    cfg_valid = 1'b0;
    start = 1'b1;
    cyc();
    start = 1'b0;
    ticks = 0;
    chk("t2_cnt0", count, 0);
    cyc();
    chk("t2_cnt1", count, 1);
    ticks += int'(tick);
    cyc();
    chk("t2_cnt2", count, 2);
    chk("t2_tick", tick, 1);
    ticks += int'(tick);
    for (int k = 0; k < 4; k++) begin
      cyc();
      ticks += int'(tick);
      chk("t2_done", done, 1);
      chk("t2_dcnt", count, 0);
      chk("t2_ready", cfg_ready, 1);
      chk("t2_drun", running, 0);
    end
    chk("t2_ticks", ticks, 1);

    // period 5 periodic, accepted from DONE
    cfg_valid    = 1'b1;
    cfg_period   = 4'd5;
    cfg_periodic = 1'b1;
    cyc();
    cfg_valid = 1'b0;
    chk("t3_idle_done", done, 0);
    chk("t3_idle_run", running, 0);
    start = 1'b1;
    cyc();
    start = 1'b0;
    cyc();
    cyc();
    cyc();
    chk("t3_cnt3", count, 3);
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    chk("t3_hold_run", running, 0);
    for (int k = 0; k < 4; k++) begin
      cyc();
      chk("t3_hold", count, 3);
      chk("t3_hold_tick", tick, 0);
    end
    start = 1'b1;
    cyc();
    start = 1'b0;
    chk("t3_resume_cnt", count, 3);
    chk("t3_resume_run", running, 1);
    cyc();
    chk("t3_cnt4", count, 4);
    chk("t3_tick", tick, 1);
    cyc();
    chk("t3_wrap", count, 0);
    chk("t3_notick", tick, 0);
    cyc();
    stop = 1'b1;
    cyc();
    chk("t3_p_cnt", count, 1);
    cyc();
    stop = 1'b0;
    chk("t3_i_cnt", count, 0);
    chk("t3_i_ready", cfg_ready, 1);

    // start+stop collisions, config during RUN
    start = 1'b1;
    stop  = 1'b1;
    cyc();
    chk("t4_idle_both", running, 0);
    stop = 1'b0;
    cyc();
    start = 1'b0;
    chk("t4_run", running, 1);
    cyc();
    chk("t4_cnt1", count, 1);
    cfg_valid    = 1'b1;
    cfg_period   = 4'd2;
    cfg_periodic = 1'b1;
    #1;
    chk("t4_ready_run", cfg_ready, 0);
    cyc();
    chk("t4_cnt2", count, 2);
    start = 1'b1;
    stop  = 1'b1;
    cyc();
    start = 1'b0;
    chk("t4_pause", running, 0);
    chk("t4_pause_cnt", count, 2);
    chk("t4_ready_pause", cfg_ready, 0);
    cyc();
    stop = 1'b0;
    chk("t4_idle_ready", cfg_ready, 1);
    cyc();
    cfg_valid = 1'b0;
    start = 1'b1;
    cyc();
    start = 1'b0;
    cyc();
    chk("t4_p2_cnt", count, 1);
    chk("t4_p2_tick", tick, 1);
    cyc();
    chk("t4_p2_wrap", count, 0);
    stop = 1'b1;
    cyc();
    cyc();
    stop = 1'b0;

    // period 0 = full wrap, then async reset
    cfg_valid    = 1'b1;
    cfg_period   = 4'd0;
    cfg_periodic = 1'b1;
    cyc();
    cfg_valid = 1'b0;
    start = 1'b1;
    cyc();
    start = 1'b0;
    for (int k = 1; k < 24; k++) begin
      cyc();
      chk("t5_cnt", count, k % 16);
      chk("t5_tick", tick, (k % 16) == 15);
    end
    chk("t5_cnt7", count, 7);
    #2;
    reset_n = 1'b0;
    #1;
    chk("t5_rst_cnt", count, 0);
    chk("t5_rst_tick", tick, 0);
    chk("t5_rst_run", running, 0);
    chk("t5_rst_ready", cfg_ready, 1);
    reset_n = 1'b1;
    cyc();
    chk("t5_post_cnt", count, 0);
    start = 1'b1;
    cyc();
    start = 1'b0;
    for (int k = 1; k < 11; k++) begin
      cyc();
      chk("t5_rp_cnt", count, k % 10);
      chk("t5_rp_tick", tick, k == 9);
    end
`else
    // prescale 4, period 2 periodic
    cfg_valid    = 1'b1;
    cfg_period   = 4'd2;
    cfg_periodic = 1'b1;
    cyc();
    cfg_valid = 1'b0;
    start = 1'b1;
    cyc();
    start = 1'b0;
    chk("p_cnt0", count, 0);
    chk("p_run", running, 1);
    ticks = 0;
    for (int k = 1; k < 25; k++) begin
      cyc();
      ticks += int'(tick);
      chk("p_cnt", count, (k / 4) % 2);
      chk("p_tick", tick, (k % 8) == 7);
    end
    chk("p_ticks", ticks, 3);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
